// File: rtl/uart_rx.sv
// Receive half of the UART link: start bit, LSB-first data, optional parity,
// one or two stop bits, sampled once per bit-rate clock after a 2-flop synchroniser.
module uart_rx #(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BAUND_RATE = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_rx_parity_err,
    output logic                         o_user_rx_frame_err
);

    // Clock and baud parameters only travel with the uart_tx parameter set.
    generate
        if (P_UART_DATA_WIDTH < 5 || P_UART_DATA_WIDTH > 9 ||
            P_UART_STOP_WIDTH < 1 || P_UART_STOP_WIDTH > 2 ||
            P_UART_CHECK < 0 || P_UART_CHECK > 2 ||
            P_UART_BAUND_RATE <= 0 || P_SYSTEM_CLK < P_UART_BAUND_RATE) begin : g_param_check
            $error("uart_rx: illegal parameter set");
        end
    endgenerate

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DATA      = 3'd1;
    localparam logic [2:0] ST_PARITY    = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    localparam logic [3:0] LAST_DATA  = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP  = 4'(P_UART_STOP_WIDTH - 1);
    localparam logic       HAS_PARITY = (P_UART_CHECK != 0);
    localparam logic       ODD_MODE   = (P_UART_CHECK == 1);

    logic                         rx_s1;
    logic                         rx_s2;
    logic [2:0]                   state;
    logic [3:0]                   bit_cnt;
    logic [P_UART_DATA_WIDTH-1:0] shreg;
    logic                         data_xor;
    logic                         parity_err;
    logic                         frame_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= i_uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // One state per line bit; the output registers load on the edge that
    // consumes the last stop bit, so IDLE already watches the following bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                <= ST_IDLE;
            bit_cnt              <= 4'd0;
            shreg                <= '0;
            data_xor             <= 1'b0;
            parity_err           <= 1'b0;
            frame_err            <= 1'b0;
            o_user_rx_data       <= '0;
            o_user_rx_valid      <= 1'b0;
            o_user_rx_parity_err <= 1'b0;
            o_user_rx_frame_err  <= 1'b0;
        end else begin
            o_user_rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s2) begin
                        bit_cnt    <= 4'd0;
                        data_xor   <= 1'b0;
                        parity_err <= 1'b0;
                        frame_err  <= 1'b0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    shreg    <= {rx_s2, shreg[P_UART_DATA_WIDTH-1:1]};
                    data_xor <= data_xor ^ rx_s2;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt <= 4'd0;
                        state   <= HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    // Odd mode flags an even ones count, even mode an odd one.
                    parity_err <= data_xor ^ rx_s2 ^ ODD_MODE;
                    state      <= ST_STOP;
                end
                ST_STOP: begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_cnt              <= 4'd0;
                        o_user_rx_data       <= shreg;
                        o_user_rx_valid      <= 1'b1;
                        o_user_rx_parity_err <= parity_err;
                        o_user_rx_frame_err  <= frame_err | ~rx_s2;
                        state                <= (frame_err | ~rx_s2) ? ST_WAIT_HIGH : ST_IDLE;
                    end else begin
                        frame_err <= frame_err | ~rx_s2;
                        bit_cnt   <= bit_cnt + 4'd1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s2) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: three parameterisations (8N1, 9O1, 8E2) driven with directed
// and random frames, checked every cycle against a frame-level expectation schedule.
module tb_uart_rx;

    localparam int NCYC = 8192;
    localparam int NLOG = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin [3];

    logic [7:0] data0;
    logic [8:0] data1;
    logic [7:0] data2;
    logic [2:0] valid;
    logic [2:0] perr;
    logic [2:0] ferr;

    always #5 clk = ~clk;

    uart_rx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_rx0 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(pin[0]),
        .o_user_rx_data(data0), .o_user_rx_valid(valid[0]),
        .o_user_rx_parity_err(perr[0]), .o_user_rx_frame_err(ferr[0]));

    uart_rx #(.P_UART_DATA_WIDTH(9), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_rx1 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(pin[1]),
        .o_user_rx_data(data1), .o_user_rx_valid(valid[1]),
        .o_user_rx_parity_err(perr[1]), .o_user_rx_frame_err(ferr[1]));

    uart_rx #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) u_rx2 (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(pin[2]),
        .o_user_rx_data(data2), .o_user_rx_valid(valid[2]),
        .o_user_rx_parity_err(perr[2]), .o_user_rx_frame_err(ferr[2]));

    // Expected word per instance and cycle, packed as {parity_err, frame_err, data}.
    bit          exp_v [3][NCYC];
    logic [10:0] exp_w [3][NCYC];
    logic [10:0] held  [3];
    logic [10:0] log_w [3][NLOG];
    int          log_t [3][NLOG];
    int          log_n [3];
    int          cyc    = 0;
    int          checks = 0;
    int          passed = 0;
    logic        exp_valid_c;
    logic [8:0]  dout_c;

    function automatic int dw_of(input int i);
        return (i == 1) ? 9 : 8;
    endfunction

    function automatic int sw_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int pm_of(input int i);
        return i;
    endfunction

    // Parity verdict from the ones count of data plus the received parity bit.
    function automatic logic model_perr(input int pm, input logic [8:0] d, input int dw, input logic pbit);
        int ones;
        ones = (pbit == 1'b1) ? 1 : 0;
        for (int j = 0; j < dw; j++) ones += (d[j] == 1'b1) ? 1 : 0;
        if (pm == 1) return (ones % 2) == 0;
        if (pm == 2) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Every cycle after the first edge, each instance must match the schedule.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            dout_c = (i == 0) ? {1'b0, data0} : (i == 1) ? data1 : {1'b0, data2};
            if (rst) held[i] = 11'h000;
            exp_valid_c = (cyc < NCYC) ? exp_v[i][cyc] : 1'b0;
            if (exp_valid_c) held[i] = exp_w[i][cyc];
            checkOutput($sformatf("cyc%0d rx%0d {valid,perr,ferr,data}", cyc, i),
                        {20'b0, valid[i], perr[i], ferr[i], dout_c},
                        {20'b0, exp_valid_c, held[i]});
            if (valid[i] === 1'b1 && log_n[i] < NLOG) begin
                log_w[i][log_n[i]] = {perr[i], ferr[i], dout_c};
                log_t[i][log_n[i]] = cyc;
                log_n[i]++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame on instance i; rst_at >= 0 aborts with a reset pulse at that bit.
    task automatic applyStimulus(input int i, input logic [8:0] d, input bit pflip,
                                 input logic [1:0] stop_zero, input int gap,
                                 input int rst_at, output int t0);
        int         dw, sw, pm, nb, vc;
        logic       pbit, ferr_m;
        logic [8:0] dm;
        logic       fb [16];
        dw = dw_of(i);
        sw = sw_of(i);
        pm = pm_of(i);
        dm = d & 9'((1 << dw) - 1);
        pbit = (pm == 1);
        for (int j = 0; j < dw; j++) pbit ^= dm[j];
        pbit ^= pflip;
        nb = 0;
        fb[nb] = 1'b0;
        nb++;
        for (int j = 0; j < dw; j++) begin
            fb[nb] = dm[j];
            nb++;
        end
        if (pm != 0) begin
            fb[nb] = pbit;
            nb++;
        end
        ferr_m = 1'b0;
        for (int s = 0; s < sw; s++) begin
            fb[nb] = ~stop_zero[s];
            ferr_m |= stop_zero[s];
            nb++;
        end
        t0 = 0;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            if (b == rst_at) begin
                rst = 1'b1;
                pin[i] = 1'b1;
                for (int k = cyc + 1; k < cyc + 48 && k < NCYC; k++)
                    for (int ii = 0; ii < 3; ii++) exp_v[ii][k] = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            pin[i] = fb[b];
            if (b == 0) begin
                t0 = cyc;
                vc = cyc + 1 + 2 + dw + ((pm != 0) ? 1 : 0) + sw;
                if (vc < NCYC) begin
                    exp_v[i][vc] = 1'b1;
                    exp_w[i][vc] = {model_perr(pm, dm, dw, pbit), ferr_m, dm};
                end
            end
        end
        repeat (gap) begin
            @(negedge clk);
            pin[i] = 1'b1;
        end
    endtask

    // Line held low: one all-zero word with a frame error, then silence until high.
    task automatic applyBreak(input int i, input int low_cycles);
        int dw, vc;
        dw = dw_of(i);
        @(negedge clk);
        pin[i] = 1'b0;
        vc = cyc + 1 + 2 + dw + ((pm_of(i) != 0) ? 1 : 0) + sw_of(i);
        exp_v[i][vc] = 1'b1;
        exp_w[i][vc] = {model_perr(pm_of(i), 9'h000, dw, 1'b0), 1'b1, 9'h000};
        repeat (low_cycles - 1) begin
            @(negedge clk);
            pin[i] = 1'b0;
        end
        @(negedge clk);
        pin[i] = 1'b1;
    endtask

    initial begin
        int         t, t_first, nb;
        int         i, gap;
        int         total;
        logic [1:0] sz;
        pin[0] = 1'b1;
        pin[1] = 1'b1;
        pin[2] = 1'b1;
        log_n[0] = 0;
        log_n[1] = 0;
        log_n[2] = 0;
        idle(3);
        rst = 1'b0;
        checkOutput("reset rx0", {20'b0, valid[0], perr[0], ferr[0], 1'b0, data0}, 32'h0);
        checkOutput("reset rx1", {20'b0, valid[1], perr[1], ferr[1], data1}, 32'h0);

        $display("[TB] idle line after reset");
        idle(100);
        total = log_n[0] + log_n[1] + log_n[2];
        checkOutput("idle valid count", 32'(total), 32'd0);
        checkOutput("idle data2", 32'(data2), 32'd0);

        $display("[TB] 8N1 back-to-back words");
        nb = log_n[0];
        applyStimulus(0, 9'h0A5, 1'b0, 2'b00, 0, -1, t_first);
        applyStimulus(0, 9'h000, 1'b0, 2'b00, 0, -1, t);
        applyStimulus(0, 9'h0FF, 1'b0, 2'b00, 0, -1, t);
        applyStimulus(0, 9'h001, 1'b0, 2'b00, 4, -1, t);
        idle(16);
        checkOutput("8N1 count", 32'(log_n[0] - nb), 32'd4);
        checkOutput("8N1 latency", 32'(log_t[0][nb] - t_first), 32'd12);
        checkOutput("8N1 w0", 32'(log_w[0][nb]), 32'h0A5);
        checkOutput("8N1 w1", 32'(log_w[0][nb + 1]), 32'h000);
        checkOutput("8N1 w2", 32'(log_w[0][nb + 2]), 32'h0FF);
        checkOutput("8N1 w3", 32'(log_w[0][nb + 3]), 32'h001);

        $display("[TB] odd parity");
        nb = log_n[1];
        applyStimulus(1, 9'h001, 1'b0, 2'b00, 2, -1, t);
        applyStimulus(1, 9'h001, 1'b1, 2'b00, 2, -1, t);
        idle(20);
        checkOutput("odd good", 32'(log_w[1][nb]), 32'h001);
        checkOutput("odd bad", 32'(log_w[1][nb + 1]), 32'h401);

        $display("[TB] even parity, two stop bits");
        nb = log_n[2];
        applyStimulus(2, 9'h003, 1'b0, 2'b00, 1, -1, t);
        applyStimulus(2, 9'h003, 1'b0, 2'b10, 1, -1, t);
        applyStimulus(2, 9'h05A, 1'b0, 2'b00, 2, -1, t);
        idle(20);
        checkOutput("even count", 32'(log_n[2] - nb), 32'd3);
        checkOutput("even good", 32'(log_w[2][nb]), 32'h003);
        checkOutput("even stop2", 32'(log_w[2][nb + 1]), 32'h203);
        checkOutput("even after", 32'(log_w[2][nb + 2]), 32'h05A);

        $display("[TB] break");
        nb = log_n[0];
        applyBreak(0, 40);
        idle(30);
        checkOutput("break count", 32'(log_n[0] - nb), 32'd1);
        checkOutput("break word", 32'(log_w[0][nb]), 32'h200);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 9'h0FF, 1'b0, 2'b00, 3, -1, t);
        idle(15);
        nb = log_n[0];
        applyStimulus(0, 9'h0C3, 1'b0, 2'b00, 0, 5, t);
        idle(5);
        checkOutput("post-reset data0", 32'(data0), 32'd0);
        checkOutput("post-reset flags", {30'b0, perr[0], ferr[0]}, 32'd0);
        applyStimulus(0, 9'h03C, 1'b0, 2'b00, 2, -1, t);
        idle(20);
        checkOutput("reset count", 32'(log_n[0] - nb), 32'd1);
        checkOutput("reset word", 32'(log_w[0][nb]), 32'h03C);

        $display("[TB] random frames");
        for (int r = 0; r < 120; r++) begin
            i = int'($urandom % 3);
            sz = 2'b00;
            if ($urandom % 8 == 0) sz = 2'($urandom_range(1, (1 << sw_of(i)) - 1));
            gap = int'($urandom % 3);
            if (sz != 2'b00 && gap == 0) gap = 1;
            applyStimulus(i, 9'($urandom), ($urandom % 8 == 0), sz, gap, -1, t);
        end
        idle(30);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the UART link. Deserialises the bit stream produced by uart_tx: start bit, data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Runs on the same bit-rate clock as uart_tx: one line bit per i_clk cycle, one sample per bit, no oversampling.
- Delivers each received word as a one-cycle valid pulse with parity-error and frame-error flags.
- Sits between the pad-side serial input and user logic.

Parameters:
- P_SYSTEM_CLK, 50_000_000, input clock frequency. Carried for parameter-set compatibility with uart_tx; not used in logic.
- P_UART_BAUND_RATE, 9600, baud rate. Carried for compatibility; not used in logic.
- P_UART_DATA_WIDTH, 8, data bits per frame, legal range 5..9.
- P_UART_STOP_WIDTH, 1, stop bits per frame, 1 or 2.
- P_UART_CHECK, 0, parity mode: 0 = none, 1 = odd, 2 = even.

Ports:
- i_clk  in  1  bit-rate clock; single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_uart_rx  in  1  serial line, idle high, asynchronous to i_clk.
- o_user_rx_data  out  P_UART_DATA_WIDTH  received word, LSB = first data bit.
- o_user_rx_valid  out  1  one-cycle pulse: data and flags valid.
- o_user_rx_parity_err  out  1  parity mismatch for the current word; qualified by valid.
- o_user_rx_frame_err  out  1  a stop bit was sampled 0; qualified by valid.

Behaviour:
- Reset: synchronous on i_rst=1 at the clock edge.
  - State returns to IDLE; both synchroniser flops are set to 1.
  - o_user_rx_data=0, o_user_rx_valid=0, o_user_rx_parity_err=0, o_user_rx_frame_err=0.
  - Reset mid-frame abandons the frame silently: no valid pulse, no flags.
- Input synchroniser:
  - Two flops, rx_s1 then rx_s2.
  - All decisions below use rx_s2, which lags the pin by 2 cycles.
- State machine: IDLE, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: when rx_s2=0, treat that cycle as the start bit, clear the bit counter and go to DATA.
  - DATA: for P_UART_DATA_WIDTH consecutive cycles, shift rx_s2 into the shift register LSB-first, so the first sampled bit ends up at bit 0. Accumulate the XOR of the sampled bits. After the last bit, go to PARITY if P_UART_CHECK>0, otherwise go to STOP.
  - PARITY: one cycle; sample rx_s2 as the parity bit.
    - Odd mode: error if XOR(data, parity) = 0.
    - Even mode: error if XOR(data, parity) = 1.
    - Go to STOP.
  - STOP: P_UART_STOP_WIDTH cycles; any stop sample of 0 sets the frame error.
    - After the last stop sample, on the next edge: load o_user_rx_data, pulse o_user_rx_valid for exactly one cycle, and drive both flags.
    - Next state is IDLE if there was no frame error, otherwise WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s2=1, then go to IDLE. A line held low (break) therefore produces one frame-error word, not a stream of them.
- Latency: o_user_rx_valid rises 2 + 1 + DW + P + SW cycles after the start-bit falling edge reaches i_uart_rx.
  - DW = P_UART_DATA_WIDTH; P = 1 if parity is enabled, else 0; SW = P_UART_STOP_WIDTH.
  - Example, 8N1: valid 12 cycles after the edge.
- Back-to-back frames: IDLE is entered on the cycle after the last stop sample and samples rx_s2 in that cycle. A zero-gap start bit is accepted with no lost frame.
- Output holding:
  - o_user_rx_data and both flags hold their values until the next valid pulse.
  - Flags are written only together with valid, and both flags may be set together.
  - There is no back-pressure: user logic must consume the word on the valid cycle.
- Parity mode 0: o_user_rx_parity_err is always 0.
- Bit-exact counterpart of uart_tx with identical parameters: a loopback from uart_tx.o_uart_tx to i_uart_rx reproduces every accepted word with no errors.

Test Plan:
- 8N1 loopback through uart_tx, words 0xA5, 0x00, 0xFF, 0x01 sent back-to-back with zero gap -> four valid pulses, data 0xA5, 0x00, 0xFF, 0x01, all flags 0, first valid 12 cycles after the first start edge.
- P_UART_CHECK=1, word 0x01 sent with parity bit 0 -> data 0x01, parity_err 0. Same word forced with parity bit 1 -> parity_err 1, data still 0x01.
- P_UART_CHECK=2, P_UART_STOP_WIDTH=2, word 0x03 sent with parity 0 -> parity_err 0. Second stop bit forced to 0 -> frame_err 1. Following frame 0x5A sent with a correct stop -> received correctly only after the line returns high.
- Line held low for 40 cycles, then high -> exactly one valid with data 0x00 and frame_err 1, then no further valid until a new start edge.
- i_rst pulsed for 1 cycle during data bit 4 of 0xC3, then a clean 0x3C sent -> no valid for 0xC3, outputs 0 after reset, 0x3C received with flags 0.
- Glitch-free idle high for 100 cycles after reset -> valid stays 0, outputs stay at reset values.
